// File: rtl/map_ram_loader.sv
// -----------------------------------------------------------------------------
// map_ram_loader
//
// Loads a 16x16 map of BITS-bit cells from a byte-oriented host stream and
// exposes a combinational read port.
//
// Command byte, bits [7:6]:
//     00  NOP
//     01  WRITE   value = in_data[BITS-1:0]; the next accepted byte is the
//                 cell address {row[7:4], col[3:0]}
//     10  FILL    value = in_data[BITS-1:0]; sweep writes every cell
//     11  BORDER  value = in_data[BITS-1:0]; sweep writes only the outer ring
//
// After reset an INIT sweep loads the default map: border cells all ones,
// interior cells zero. Every sweep takes exactly 256 cycles.
//
// Ports:
//     clk       system clock, rising-edge active
//     reset     synchronous active-high reset
//     in_data   command / argument byte from the host
//     in_valid  in_data holds a byte
//     in_ready  byte is accepted this cycle (registered)
//     row, col  read-port cell coordinates
//     val       cell value at (row, col), combinational read of the array
//     busy      high while an INIT, FILL or BORDER sweep runs (registered)
//
// BITS must lie in 1..6 so the value field never overlaps the opcode.
// -----------------------------------------------------------------------------
module map_ram_loader #(
    parameter int BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      row,
    input  logic [3:0]      col,
    output logic [BITS-1:0] val,
    output logic            busy
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ADDR   = 3'd2,
        ST_FILL   = 3'd3,
        ST_BORDER = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_BORDER = 2'b11;

    // A cell lies on the border when its row or column is 0 or 15.
    function automatic logic is_border(input logic [7:0] addr);
        return (addr[7:4] == 4'h0) || (addr[7:4] == 4'hF) ||
               (addr[3:0] == 4'h0) || (addr[3:0] == 4'hF);
    endfunction

    state_t          state_q,    state_d;
    logic [7:0]      cnt_q,      cnt_d;
    logic [BITS-1:0] value_q,    value_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q,     busy_d;

    logic            accept_s;
    logic            we_s;
    logic [7:0]      waddr_s;
    logic [BITS-1:0] wdata_s;

    logic [BITS-1:0] mem_q [256];

    // Next-state, sweep counter, latched value and write-port decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        we_s     = 1'b0;
        waddr_s  = cnt_q;
        wdata_s  = value_q;
        accept_s = in_valid && in_ready_q;

        case (state_q)
            ST_INIT: begin
                we_s    = 1'b1;
                wdata_s = is_border(cnt_q) ? {BITS{1'b1}} : {BITS{1'b0}};
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end

            ST_IDLE: begin
                if (accept_s) begin
                    case (in_data[7:6])
                        OP_NOP: begin
                            state_d = ST_IDLE;
                        end
                        OP_WRITE: begin
                            value_d = in_data[BITS-1:0];
                            state_d = ST_ADDR;
                        end
                        OP_FILL: begin
                            value_d = in_data[BITS-1:0];
                            cnt_d   = 8'd0;
                            state_d = ST_FILL;
                        end
                        OP_BORDER: begin
                            value_d = in_data[BITS-1:0];
                            cnt_d   = 8'd0;
                            state_d = ST_BORDER;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADDR: begin
                // The address byte itself is written in its acceptance cycle.
                if (accept_s) begin
                    we_s    = 1'b1;
                    waddr_s = in_data;
                    wdata_s = value_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ADDR;
                end
            end

            ST_FILL: begin
                we_s  = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_BORDER: begin
                // Interior cells are skipped but still cost one cycle each,
                // so every sweep has the same 256-cycle length.
                we_s  = is_border(cnt_q);
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BORDER;
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = 8'd0;
            end
        endcase

        // Handshake and status outputs are registered from the next state.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR);
        busy_d     = (state_d == ST_INIT) || (state_d == ST_FILL) ||
                     (state_d == ST_BORDER);
    end

    // FSM state, sweep counter, latched value and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= 8'd0;
            value_q    <= {BITS{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Map storage; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (we_s && !reset) begin
            mem_q[waddr_s] <= wdata_s;
        end else begin
            mem_q[waddr_s] <= mem_q[waddr_s];
        end
    end

    // Read port sees stored contents, so a same-cycle write shows next cycle.
    assign val      = mem_q[{row, col}];
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_map_ram_loader.sv
module tb_map_ram_loader;

    localparam int BITS = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      row;
    logic [3:0]      col;
    logic [BITS-1:0] val;
    logic            busy;

    map_ram_loader #(.BITS(BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .row      (row),
        .col      (col),
        .val      (val),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [BITS-1:0] model [256];
    logic [BITS-1:0] val_at_accept;

    typedef struct {
        logic [7:0]      addr;
        logic [BITS-1:0] val;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0]      cmd;
        logic [7:0]      addr;
        int              gap;
        logic [BITS-1:0] exp_val;
    } vec_t;

    function automatic logic edge_cell(input int a);
        return (a / 16 == 0) || (a / 16 == 15) || (a % 16 == 0) || (a % 16 == 15);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_default();
        for (int i = 0; i < 256; i++) model[i] = edge_cell(i) ? 2'b11 : 2'b00;
    endtask

    task automatic check_cell(input string name, input logic [3:0] r, input logic [3:0] c,
                              input logic [BITS-1:0] exp);
        row = r;
        col = c;
        #1;
        check(name, val, exp);
    endtask

    // Read every cell against the model; one comparison for the whole map.
    task automatic check_map(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            row = i[7:4];
            col = i[3:0];
            #1;
            if (val !== model[i]) bad++;
        end
        check(name, bad, 0);
        @(posedge clk);
        #1;
    endtask

    // Present a byte until accepted; returns the number of refused cycles.
    task automatic send_byte(input logic [7:0] b, output int waited);
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited >= 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: byte %0h never accepted", b);
                break;
            end
        end
        val_at_accept = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic sweep_wait(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Address byte of a WRITE; expectation goes through the scoreboard.
    task automatic write_addr(input logic [7:0] addr, input logic [BITS-1:0] exp,
                              input string name);
        int  w;
        sb_t e;
        row = addr[7:4];
        col = addr[3:0];
        sb_q.push_back('{addr: addr, val: exp});
        send_byte(addr, w);
        check({name, "_addr_wait"}, w, 0);
        check({name, "_same_cycle_old"}, val_at_accept, model[addr]);
        e = sb_q.pop_front();
        row = e.addr[7:4];
        col = e.addr[3:0];
        #1;
        check(name, val, e.val);
        model[e.addr] = e.val;
    endtask

    task automatic write_pair(input logic [7:0] cmd, input logic [7:0] addr, input int gap,
                              input logic [BITS-1:0] exp, input string name);
        int w;
        send_byte(cmd, w);
        check({name, "_cmd_wait"}, w, 0);
        check({name, "_addr_ready"}, {busy, in_ready}, 2'b01);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        write_addr(addr, exp, name);
    endtask

    initial begin
        vec_t vecs [6];
        int   n;
        int   w;

        vecs[0] = '{cmd: 8'h42, addr: 8'h35, gap: 3, exp_val: 2'd2};
        vecs[1] = '{cmd: 8'h41, addr: 8'h00, gap: 0, exp_val: 2'd1};
        vecs[2] = '{cmd: 8'h43, addr: 8'hA9, gap: 1, exp_val: 2'd3};
        vecs[3] = '{cmd: 8'h40, addr: 8'hFF, gap: 2, exp_val: 2'd0};
        vecs[4] = '{cmd: 8'h7E, addr: 8'h12, gap: 0, exp_val: 2'd2};
        vecs[5] = '{cmd: 8'h5D, addr: 8'hC3, gap: 5, exp_val: 2'd1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        row      = 4'h0;
        col      = 4'h0;

        // Reset and INIT sweep.
        @(posedge clk);
        #1;
        check("reset_busy_ready", {busy, in_ready}, 2'b10);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sweep_wait(n);
        check("init_length", n, 256);
        check("init_done_ready", {busy, in_ready}, 2'b01);
        model_default();
        check_cell("init_0_5", 4'd0, 4'd5, 2'd3);
        check_cell("init_15_15", 4'd15, 4'd15, 2'd3);
        check_cell("init_7_0", 4'd7, 4'd0, 2'd3);
        check_cell("init_7_7", 4'd7, 4'd7, 2'd0);
        check_cell("init_1_14", 4'd1, 4'd14, 2'd0);
        check_map("init_map");

        // Table of WRITE pairs.
        for (int i = 0; i < 6; i++) begin
            write_pair(vecs[i].cmd, vecs[i].addr, vecs[i].gap, vecs[i].exp_val,
                       $sformatf("write%0d", i));
        end
        check_map("writes_map");

        // NOP stream.
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h00, w);
            check("nop_wait", w, 0);
            check("nop_ready", {busy, in_ready}, 2'b01);
        end
        check_map("nop_map");

        // FILL 1 with a live read partway through the sweep.
        row = 4'd15;
        col = 4'd14;
        send_byte(8'h81, w);
        check("fill_start", {busy, in_ready}, 2'b10);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 20) begin
                check("fill_partial_unswept", val, model[8'hFE]);
                row = 4'd0;
                col = 4'd5;
                #1;
                check("fill_partial_swept", val, 2'd1);
            end
        end
        check("fill_length", n, 256);
        for (int i = 0; i < 256; i++) model[i] = 2'd1;
        check_map("fill_map");

        // BORDER 0.
        send_byte(8'hC0, w);
        check("border_start", {busy, in_ready}, 2'b10);
        sweep_wait(n);
        check("border_length", n, 256);
        for (int i = 0; i < 256; i++) if (edge_cell(i)) model[i] = 2'd0;
        check_map("border_map");

        // Reset in the middle of a FILL sweep restarts INIT.
        send_byte(8'h82, w);
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sweep_wait(n);
        check("midsweep_init_length", n, 256);
        model_default();
        check_map("midsweep_map");

        // Command held valid across reset and INIT.
        in_data  = 8'h41;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("held_reset_status", {busy, in_ready}, 2'b10);
        reset = 1'b0;
        send_byte(8'h41, w);
        check("held_accept_delay", w, 256);
        check("held_in_addr", {busy, in_ready}, 2'b01);
        write_addr(8'h9A, 2'd1, "held_write");
        check_map("held_map");

        // Pending WRITE discarded by reset; next byte is a command.
        send_byte(8'h43, w);
        check("discard_in_addr", {busy, in_ready}, 2'b01);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("discard_reset_busy", {busy, in_ready}, 2'b10);
        reset = 1'b0;
        send_byte(8'h77, w);
        check("discard_init_delay", w, 256);
        model_default();
        check_cell("discard_7_7", 4'd7, 4'd7, 2'd0);
        check("discard_now_addr", {busy, in_ready}, 2'b01);
        write_addr(8'h22, 2'd3, "discard_write");
        check_map("discard_map");

        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
